// File: rtl/decoder_ingress_scheduler_pkg.sv
// Shared types and defaults for the two-source decoder ingress scheduler.
package decoder_ingress_scheduler_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned WCNT_W          = 15;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;
  localparam int unsigned MAX_WORDS_DEF   = 16384;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STREAM   = 3'd1,
    ST_WAIT_FIN = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_REPORT   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNDERRUN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_OVERSIZE = 2'b11
  } res_err_e;

endpackage

// File: rtl/decoder_ingress_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: the source not granted last wins a tie.
module decoder_ingress_scheduler_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_src,
  output logic       gnt_valid_c,
  output logic       gnt_src_c
);

  logic last_src;

  // Reset to "source 1 went last" so source 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_src <= 1'b1;
    end else if (upd) begin
      last_src <= upd_src;
    end
  end

  always_comb begin
    gnt_valid_c = |req;
    gnt_src_c   = 1'b0;
    if (req == 2'b11) begin
      gnt_src_c = ~last_src;
    end else begin
      gnt_src_c = req[1];
    end
  end

endmodule

// File: rtl/decoder_ingress_scheduler.sv
// Grants one of two IPv4 frame sources at a time to a shared decoder and
// reports the per-frame decode result or the error that aborted it.
module decoder_ingress_scheduler
  import decoder_ingress_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned MAX_WORDS   = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        s_valid,
  input  logic [DATA_W-1:0] s_data0,
  input  logic [DATA_W-1:0] s_data1,
  input  logic [1:0]        s_last,
  output logic [1:0]        s_ready,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_start,
  output logic              dec_rst,
  input  logic              dec_ok,
  input  logic              dec_fin,
  output logic              res_valid,
  output logic              res_src,
  output logic              res_ok,
  output logic [1:0]        res_err
);

  localparam int unsigned       TCNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCNT_W-1:0] MAX_WCNT  = WCNT_W'(MAX_WORDS);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  state_e            state;
  logic              gnt_src;
  logic [WCNT_W-1:0] wcnt;
  logic [TCNT_W-1:0] tcnt;
  logic              fin_seen;
  logic              ok_seen;
  res_err_e          err_q;

  logic              arb_valid;
  logic              arb_src;
  logic              report_upd;
  logic              accept;
  logic              cur_last;
  logic [DATA_W-1:0] cur_data;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              oversize;

  assign report_upd = (state == ST_REPORT);
  assign accept     = s_valid[gnt_src] & s_ready[gnt_src];
  assign cur_last   = s_last[gnt_src];
  assign cur_data   = gnt_src ? s_data1 : s_data0;
  assign wcnt_inc   = wcnt + WCNT_W'(1);
  assign oversize   = (wcnt_inc > MAX_WCNT);

  decoder_ingress_scheduler_rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .reset       (reset),
    .req         (s_valid),
    .upd         (report_upd),
    .upd_src     (gnt_src),
    .gnt_valid_c (arb_valid),
    .gnt_src_c   (arb_src)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      gnt_src   <= 1'b0;
      wcnt      <= '0;
      tcnt      <= '0;
      fin_seen  <= 1'b0;
      ok_seen   <= 1'b0;
      err_q     <= ERR_NONE;
      s_ready   <= 2'b00;
      dec_data  <= '0;
      dec_start <= 1'b0;
      dec_rst   <= 1'b1;
      res_valid <= 1'b0;
      res_src   <= 1'b0;
      res_ok    <= 1'b0;
      res_err   <= ERR_NONE;
    end else begin
      dec_start <= 1'b0;
      dec_rst   <= 1'b0;
      res_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            state    <= ST_STREAM;
            gnt_src  <= arb_src;
            s_ready  <= arb_src ? 2'b10 : 2'b01;
            wcnt     <= '0;
            fin_seen <= 1'b0;
            ok_seen  <= 1'b0;
            err_q    <= ERR_NONE;
          end
        end

        ST_STREAM: begin
          // A fin that arrives while words are still flowing is held for the report.
          if (dec_fin && !fin_seen) begin
            fin_seen <= 1'b1;
            ok_seen  <= dec_ok;
          end
          if (accept) begin
            wcnt <= wcnt_inc;
            if (oversize) begin
              err_q   <= ERR_OVERSIZE;
              s_ready <= 2'b00;
              dec_rst <= 1'b1;
              state   <= ST_FLUSH;
            end else begin
              dec_data  <= cur_data;
              dec_start <= (wcnt == '0);
              if (cur_last) begin
                s_ready <= 2'b00;
                tcnt    <= '0;
                if (fin_seen || dec_fin) begin
                  state     <= ST_REPORT;
                  res_valid <= 1'b1;
                  res_src   <= gnt_src;
                  res_ok    <= fin_seen ? ok_seen : dec_ok;
                  res_err   <= ERR_NONE;
                end else begin
                  state <= ST_WAIT_FIN;
                end
              end
            end
          end else if (wcnt != '0) begin
            err_q   <= ERR_UNDERRUN;
            s_ready <= 2'b00;
            dec_rst <= 1'b1;
            state   <= ST_FLUSH;
          end
        end

        ST_WAIT_FIN: begin
          // fin on the expiry cycle still counts as a normal finish.
          if (dec_fin) begin
            state     <= ST_REPORT;
            res_valid <= 1'b1;
            res_src   <= gnt_src;
            res_ok    <= dec_ok;
            res_err   <= ERR_NONE;
          end else if (tcnt == TCNT_LAST) begin
            err_q   <= ERR_TIMEOUT;
            dec_rst <= 1'b1;
            state   <= ST_FLUSH;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end

        ST_FLUSH: begin
          state     <= ST_REPORT;
          res_valid <= 1'b1;
          res_src   <= gnt_src;
          res_ok    <= 1'b0;
          res_err   <= err_q;
        end

        ST_REPORT: begin
          state <= ST_IDLE;
        end

        default: begin
          state   <= ST_IDLE;
          s_ready <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_ingress_scheduler.sv
// Directed bench for decoder_ingress_scheduler: two instances share stimulus,
// one with MAX_WORDS=4 for the oversize case, the other for everything else.
module tb_decoder_ingress_scheduler;

  typedef struct packed {
    logic       src;
    logic       ok;
    logic [1:0] err;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  s_valid;
  logic [31:0] s_data0, s_data1;
  logic [1:0]  s_last;
  logic        dec_ok, dec_fin;

  logic [1:0]  s_ready,   o_s_ready;
  logic [31:0] dec_data,  o_dec_data;
  logic        dec_start, o_dec_start;
  logic        dec_rst,   o_dec_rst;
  logic        res_valid, o_res_valid;
  logic        res_src,   o_res_src;
  logic        res_ok,    o_res_ok;
  logic [1:0]  res_err,   o_res_err;

  logic        sel;
  logic [1:0]  m_ready;
  logic [31:0] m_dec_data;
  logic        m_dec_start, m_dec_rst, m_res_valid, m_res_src, m_res_ok;
  logic [1:0]  m_res_err;

  always #5 clk = ~clk;

  decoder_ingress_scheduler #(.TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data0(s_data0), .s_data1(s_data1),
    .s_last(s_last), .s_ready(s_ready), .dec_data(dec_data), .dec_start(dec_start),
    .dec_rst(dec_rst), .dec_ok(dec_ok), .dec_fin(dec_fin), .res_valid(res_valid),
    .res_src(res_src), .res_ok(res_ok), .res_err(res_err)
  );

  decoder_ingress_scheduler #(.TIMEOUT_CYC(16), .MAX_WORDS(4)) u_dut_ovs (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data0(s_data0), .s_data1(s_data1),
    .s_last(s_last), .s_ready(o_s_ready), .dec_data(o_dec_data), .dec_start(o_dec_start),
    .dec_rst(o_dec_rst), .dec_ok(dec_ok), .dec_fin(dec_fin), .res_valid(o_res_valid),
    .res_src(o_res_src), .res_ok(o_res_ok), .res_err(o_res_err)
  );

  assign m_ready     = sel ? o_s_ready   : s_ready;
  assign m_dec_data  = sel ? o_dec_data  : dec_data;
  assign m_dec_start = sel ? o_dec_start : dec_start;
  assign m_dec_rst   = sel ? o_dec_rst   : dec_rst;
  assign m_res_valid = sel ? o_res_valid : res_valid;
  assign m_res_src   = sel ? o_res_src   : res_src;
  assign m_res_ok    = sel ? o_res_ok    : res_ok;
  assign m_res_err   = sel ? o_res_err   : res_err;

  // Source model state: frames left, word index, length, valid cut-off, data base.
  int          frames[2], idx[2], len[2], stop_at[2];
  logic [31:0] base[2];

  int          checks = 0, errors = 0;
  int          cyc = 0;
  logic [1:0]  acc_hit;
  logic [31:0] acc_word;
  int          acc_idx;
  logic        acc_last;

  int          n_acc = 0, n_last = 0, n_start = 0, n_rst = 0, n_res = 0;
  int          last_acc_edge = 0, rst_rise_edge = 0, res_edge = 0;
  int          rst_w = 0, last_rst_w = 0;
  logic        prev_rst = 1'b0;
  int          max_fwd = 1000;
  logic [31:0] last_fwd = 32'h0;
  res_t        res_q[$];

  // Handshake capture on the active edge; everything else is sampled at negedge.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    acc_hit <= s_valid & m_ready;
    if (s_valid[0] & m_ready[0]) begin
      acc_word <= s_data0;
      acc_idx  <= idx[0];
      acc_last <= s_last[0];
    end else begin
      acc_word <= s_data1;
      acc_idx  <= idx[1];
      acc_last <= s_last[1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic apply_src();
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = (frames[i] > 0) && (idx[i] < stop_at[i]);
      s_last[i]  = (idx[i] == len[i] - 1);
    end
    s_data0 = base[0] + 32'(idx[0]);
    s_data1 = base[1] + 32'(idx[1]);
  endtask

  task automatic start_src(input int i, input logic [31:0] b, input int l, input int stop, input int nfr);
    base[i]    = b;
    len[i]     = l;
    stop_at[i] = stop;
    frames[i]  = nfr;
    idx[i]     = 0;
    apply_src();
  endtask

  // One cycle: check forwarding and per-cycle invariants, log events, advance sources.
  task automatic tick();
    logic exp_start;
    @(negedge clk);
    exp_start = 1'b0;
    if (|acc_hit) begin
      n_acc++;
      if (acc_idx < max_fwd) begin
        check("fwd_data", m_dec_data, acc_word);
        exp_start = (acc_idx == 0);
        last_fwd  = acc_word;
      end else begin
        check("drop_hold", m_dec_data, last_fwd);
      end
      if (acc_last) begin
        n_last++;
        last_acc_edge = cyc - 1;
      end
    end
    check("dec_start", 32'(m_dec_start), 32'(exp_start));
    check("ready_onehot", 32'($countones(m_ready) <= 1), 32'd1);
    if (m_dec_start) n_start++;
    if (m_dec_rst) begin
      if (!prev_rst) begin
        n_rst++;
        rst_rise_edge = cyc - 1;
      end
      rst_w++;
    end else if (prev_rst) begin
      last_rst_w = rst_w;
      rst_w      = 0;
    end
    prev_rst = m_dec_rst;
    if (m_res_valid) begin
      res_q.push_back('{src: m_res_src, ok: m_res_ok, err: m_res_err});
      res_edge = cyc - 1;
      n_res++;
    end
    for (int i = 0; i < 2; i++) begin
      if (acc_hit[i]) begin
        if (idx[i] == len[i] - 1) begin
          idx[i]    = 0;
          frames[i] = frames[i] - 1;
          base[i]   = base[i] + 32'h100;
        end else begin
          idx[i]++;
        end
      end
    end
    apply_src();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      frames[i] = 0;
      idx[i]    = 0;
    end
    apply_src();
    tick();
    tick();
    reset    = 1'b0;
    last_fwd = 32'h0;
    res_q.delete();
    tick();
  endtask

  task automatic expect_res(input string tag, input logic src, input logic ok, input logic [1:0] err);
    int   n = 0;
    res_t r;
    while (res_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(res_q.size() > 0), 32'd1);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      check({tag, "_src"}, 32'(r.src), 32'(src));
      check({tag, "_ok"},  32'(r.ok),  32'(ok));
      check({tag, "_err"}, 32'(r.err), 32'(err));
    end
  endtask

  task automatic wait_last(input int target);
    int n = 0;
    while (n_last < target && n < 200) begin
      tick();
      n++;
    end
    check("last_seen", 32'(n_last >= target), 32'd1);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (n_acc < target && n < 200) begin
      tick();
      n++;
    end
    check("acc_seen", 32'(n_acc >= target), 32'd1);
  endtask

  initial begin
    int a0, s0, r0, q0, n;
    reset   = 1'b1;
    sel     = 1'b0;
    dec_fin = 1'b0;
    dec_ok  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      frames[i]  = 0;
      idx[i]     = 0;
      len[i]     = 1;
      stop_at[i] = 1000;
      base[i]    = 32'h0;
    end
    apply_src();
    repeat (3) tick();

    // Values held during reset
    check("rst_ready",     32'(s_ready),   32'd0);
    check("rst_dec_data",  dec_data,       32'd0);
    check("rst_dec_start", 32'(dec_start), 32'd0);
    check("rst_dec_rst",   32'(dec_rst),   32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_src",   32'(res_src),   32'd0);
    check("rst_res_ok",    32'(res_ok),    32'd0);
    check("rst_res_err",   32'(res_err),   32'd0);
    reset = 1'b0;
    tick();
    check("idle_dec_rst", 32'(dec_rst), 32'd0);

    // Single 6-word frame from source 0, fin+ok two cycles after the last accept
    s0 = n_start;
    start_src(0, 32'hA000_0000, 6, 1000, 1);
    wait_last(1);
    tick();
    dec_fin = 1'b1;
    dec_ok  = 1'b1;
    tick();
    dec_fin = 1'b0;
    dec_ok  = 1'b0;
    expect_res("single", 1'b0, 1'b1, 2'b00);
    check("single_starts", 32'(n_start - s0), 32'd1);

    // Contention: both sources valid in the same IDLE cycle, two frames each
    do_reset();
    a0 = n_acc;
    s0 = n_start;
    dec_fin = 1'b1;
    dec_ok  = 1'b1;
    start_src(0, 32'hB000_0000, 3, 1000, 2);
    start_src(1, 32'hC000_0000, 3, 1000, 2);
    expect_res("rr0", 1'b0, 1'b1, 2'b00);
    expect_res("rr1", 1'b1, 1'b1, 2'b00);
    expect_res("rr2", 1'b0, 1'b1, 2'b00);
    expect_res("rr3", 1'b1, 1'b1, 2'b00);
    check("rr_words",  32'(n_acc - a0),   32'd12);
    check("rr_starts", 32'(n_start - s0), 32'd4);
    dec_fin = 1'b0;
    dec_ok  = 1'b0;
    tick();

    // Underrun: source 1 stops after word 3 of 8
    r0 = n_rst;
    start_src(1, 32'hD000_0000, 8, 3, 1);
    expect_res("underrun", 1'b1, 1'b0, 2'b01);
    check("ur_rst_pulses",  32'(n_rst - r0),              32'd1);
    check("ur_rst_width",   32'(last_rst_w),              32'd1);
    check("ur_rst_to_res",  32'(res_edge - rst_rise_edge), 32'd1);
    frames[1] = 0;
    idx[1]    = 0;
    apply_src();
    tick();

    // Timeout: no fin after the last word
    q0 = n_last;
    start_src(0, 32'hE000_0000, 4, 1000, 1);
    wait_last(q0 + 1);
    expect_res("timeout", 1'b0, 1'b0, 2'b10);
    check("to_delay", 32'(rst_rise_edge - last_acc_edge), 32'd16);

    // Timeout race: fin arrives on the 16th wait cycle and wins
    r0 = n_rst;
    q0 = n_last;
    start_src(0, 32'hE100_0000, 4, 1000, 1);
    wait_last(q0 + 1);
    n = 0;
    while (cyc != last_acc_edge + 16 && n < 40) begin
      tick();
      n++;
    end
    dec_fin = 1'b1;
    dec_ok  = 1'b1;
    tick();
    dec_fin = 1'b0;
    dec_ok  = 1'b0;
    expect_res("fin_at_16", 1'b0, 1'b1, 2'b00);
    check("fin16_no_rst", 32'(n_rst - r0), 32'd0);

    // Early fin after word 2 of 5: all words forwarded, one report, no WAIT_FIN
    a0 = n_acc;
    q0 = n_res;
    start_src(0, 32'hF000_0000, 5, 1000, 1);
    wait_acc(a0 + 2);
    dec_fin = 1'b1;
    dec_ok  = 1'b1;
    tick();
    dec_fin = 1'b0;
    dec_ok  = 1'b0;
    expect_res("early_fin", 1'b0, 1'b1, 2'b00);
    check("ef_words",    32'(n_acc - a0),             32'd5);
    check("ef_direct",   32'(res_edge - last_acc_edge), 32'd0);
    repeat (10) tick();
    check("ef_one_res",  32'(n_res - q0),              32'd1);

    // Oversize on the MAX_WORDS=4 instance: word 5 consumed but not forwarded
    do_reset();
    sel     = 1'b1;
    max_fwd = 4;
    a0 = n_acc;
    s0 = n_start;
    start_src(0, 32'h1000_0000, 5, 1000, 1);
    expect_res("oversize", 1'b0, 1'b0, 2'b11);
    check("ovs_words",  32'(n_acc - a0),   32'd5);
    check("ovs_starts", 32'(n_start - s0), 32'd1);
    check("ovs_data",   o_dec_data,        32'h1000_0003);
    max_fwd = 1000;
    sel     = 1'b0;

    // Reset in the middle of a frame from source 1
    do_reset();
    a0 = n_acc;
    q0 = n_res;
    start_src(1, 32'h2000_0000, 8, 1000, 1);
    wait_acc(a0 + 3);
    reset     = 1'b1;
    frames[1] = 0;
    idx[1]    = 0;
    apply_src();
    tick();
    check("mid_rst_ready",     32'(s_ready),   32'd0);
    check("mid_rst_dec_rst",   32'(dec_rst),   32'd1);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_dec_data",  dec_data,       32'd0);
    tick();
    reset    = 1'b0;
    last_fwd = 32'h0;
    repeat (5) tick();
    check("mid_rst_no_res", 32'(n_res - q0), 32'd0);
    dec_fin = 1'b1;
    dec_ok  = 1'b1;
    start_src(0, 32'h3000_0000, 2, 1000, 1);
    start_src(1, 32'h4000_0000, 2, 1000, 1);
    expect_res("post_rst0", 1'b0, 1'b1, 2'b00);
    expect_res("post_rst1", 1'b1, 1'b1, 2'b00);
    dec_fin = 1'b0;
    dec_ok  = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_ingress_scheduler.md
DECODER_INGRESS_SCHEDULER -- requirements
Module: decoder_ingress_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: maximum cycles in WAIT_FIN before abort.
REQ-002 Parameter MAX_WORDS, default 16384: maximum 32-bit words per frame (65535-byte IPv4 datagram rounded up).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  2  per-source word valid (index 0, 1).
REQ-006 s_data0, s_data1  input  32  per-source IPv4 frame word.
REQ-007 s_last  input  2  per-source final-word marker.
REQ-008 s_ready  output  2  per-source word accept.
REQ-009 dec_data  output  32  word to the combined decoder data input.
REQ-010 dec_start  output  1  one-cycle pulse coincident with the first word on dec_data.
REQ-011 dec_rst  output  1  decoder reset: reset OR the FLUSH state.
REQ-012 dec_ok, dec_fin  input  1 each  combined decoder ok/fin.
REQ-013 res_valid  output  1  one-cycle result pulse.
REQ-014 res_src  output  1  source of the reported frame.
REQ-015 res_ok  output  1  dec_ok sampled at dec_fin; 0 on any error.
REQ-016 res_err  output  2  00 none, 01 underrun, 10 timeout, 11 oversize.

Function
REQ-017 States: IDLE, STREAM, WAIT_FIN, FLUSH, REPORT.
- Only one frame is in flight at a time.
REQ-018 IDLE grant:
- Occurs when any s_valid is high.
- Sole requester wins.
- If both request, round-robin: the source not granted last wins; after reset, source 0 has priority.
- Next state is STREAM.
REQ-019 STREAM: s_ready is high only for the granted source; s_ready is 0 in all other states and for the other source.
REQ-020 Forwarding timing:
- A word accepted (valid and ready) in cycle N appears on dec_data in cycle N+1.
- dec_start is 1 in N+1 for the frame's first word only.
- dec_data holds its last value otherwise.
REQ-021 Underrun: if the granted s_valid is low in STREAM after the first word and before last, set res_err=01 and go to FLUSH.
REQ-022 Word counter:
- 15-bit, increments per accepted word.
- If the accepted word count exceeds MAX_WORDS without last, set res_err=11, drop the word (not forwarded), and go to FLUSH.
REQ-023 Accepted last word: forward it, clear the timeout counter, go to WAIT_FIN.
REQ-024 Early dec_fin during STREAM:
- Latch fin and dec_ok.
- Keep forwarding until last, then go directly to REPORT (skip WAIT_FIN).
REQ-025 WAIT_FIN:
- dec_fin=1 latches dec_ok and goes to REPORT.
- Counter reaching TIMEOUT_CYC with no fin sets res_err=10 and goes to FLUSH.
- dec_fin in the same cycle as expiry counts as fin (fin wins).
REQ-026 FLUSH: assert dec_rst for exactly 1 cycle, then go to REPORT.
REQ-027 REPORT:
- res_valid=1 for 1 cycle with res_src, res_ok, res_err.
- Update round-robin pointer to the granted source.
- Go to IDLE.
- Minimum gap between frames is therefore 2 cycles (REPORT, IDLE).
REQ-028 Source words are never re-ordered or duplicated; words from the non-granted source are never consumed.

Reset
REQ-029 While reset=1: state IDLE, s_ready=00, dec_data=0, dec_start=0, dec_rst=1, res_valid=0, res_src=0, res_ok=0, res_err=00, counters 0, round-robin pointer favours source 0.
REQ-030 Reset mid-frame abandons the frame with no res_valid; the sources must restart their frames.

Structure
REQ-031 The shared package holds the state encoding, the res_err codes, and default TIMEOUT_CYC/MAX_WORDS.
REQ-032 One sub-module, rr_arb2: a 2-way round-robin arbiter with request, grant, and pointer-update inputs.
REQ-033 The block instantiates no decoder; it drives one combined decoder at the top level.

Verification
REQ-034 Single frame:
- Stimulus: source 0 sends 6 words, last on the 6th; dec_fin/dec_ok=1 two cycles later.
- Required: dec_start on word 1 one cycle after accept, then res_valid with src=0, ok=1, err=00.
REQ-035 Contention:
- Stimulus: both sources valid in the same IDLE cycle after reset, repeated twice.
- Required: grant order 0, 1, 0, 1; no interleaved words on dec_data.
REQ-036 Underrun:
- Stimulus: source 1 drops s_valid after word 3 of 8.
- Required: dec_rst pulse of 1 cycle, then res_err=01, ok=0, src=1.
REQ-037 Timeout:
- Stimulus: frame ends with TIMEOUT_CYC=16 and no dec_fin.
- Required: dec_rst 16 cycles after last accept, then res_err=10.
- Repeat with dec_fin on cycle 16: required res_err=00.
REQ-038 Oversize/early fin:
- Stimulus: MAX_WORDS=4 with a 5-word frame.
- Required: res_err=11 and word 5 not forwarded.
- Stimulus: dec_fin at word 2 of 5.
- Required: all 5 words forwarded, then a single res_valid.
REQ-039 Reset mid-STREAM:
- Stimulus: reset at word 3.
- Required: s_ready=00, dec_rst=1, no res_valid, next frame granted to source 0.
